// File: rtl/pdh_dac_axis_if.sv
// AXI-Stream bundle between the DAC transmit path and the platform DAC adapter.
interface pdh_dac_axis_if #(
    parameter int TDATA_WIDTH = 32
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pdh_dac_axis_tx.sv
// Saturates pdh_core control outputs, packs them and streams them to the DAC.
// Optional test ramp source: define PDH_DAC_TEST_RAMP_EN.
module pdh_dac_axis_tx #(
    parameter int IN_WIDTH         = 16,
    parameter int DAC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int DROP_CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable_i,
    input  logic                            clear_i,
    input  logic signed [IN_WIDTH-1:0]      ch_a_i,
    input  logic signed [IN_WIDTH-1:0]      ch_b_i,
    input  logic                            in_valid_i,
    pdh_dac_axis_if.master                  M_AXIS,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
    output logic [DROP_CNT_WIDTH-1:0]       drop_cnt_o,
    output logic [1:0]                      sat_flag_o
);

    localparam int DW = DAC_DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int HW = AXIS_TDATA_WIDTH - 16;

    localparam logic signed [IN_WIDTH-1:0] SMAX =
        IN_WIDTH'((1 <<< (DW - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SMIN = ~SMAX;

    if (AXIS_TDATA_WIDTH < 2 * DW || DW > 16 || IN_WIDTH <= DW) begin : g_bad_width
        $error("pdh_dac_axis_tx: unsupported data widths");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pdh_dac_axis_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    // {clip, value}
    function automatic logic [DW:0] sat(input logic signed [IN_WIDTH-1:0] x);
        if (x > SMAX) begin
            return {1'b1, SMAX[DW-1:0]};
        end else if (x < SMIN) begin
            return {1'b1, SMIN[DW-1:0]};
        end else begin
            return {1'b0, x[DW-1:0]};
        end
    endfunction

    logic              accept;
    logic [DW-1:0]     a_in;
    logic [DW-1:0]     b_in;
    logic [1:0]        clip;

    assign accept = in_valid_i && enable_i && !clear_i;

`ifdef PDH_DAC_TEST_RAMP_EN
    logic [DW-1:0] ramp_q;
    logic [DW-1:0] ramp_d;
    logic          unused_ch;

    assign unused_ch = ^{ch_a_i, ch_b_i};

    always_comb begin
        a_in   = ramp_q;
        b_in   = ~ramp_q;
        clip   = 2'b00;
        ramp_d = ramp_q;
        if (accept) begin
            ramp_d = ramp_q + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    logic [DW:0] a_sat;
    logic [DW:0] b_sat;

    always_comb begin
        a_sat = sat(ch_a_i);
        b_sat = sat(ch_b_i);
        a_in  = a_sat[DW-1:0];
        b_in  = b_sat[DW-1:0];
        clip  = {b_sat[DW], a_sat[DW]};
    end
`endif

    logic                        s1_valid_q, s1_valid_d;
    logic [DW-1:0]               s1_a_q, s1_a_d;
    logic [DW-1:0]               s1_b_q, s1_b_d;
    logic [1:0]                  sat_q, sat_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]               level_q, level_d;
    logic [DROP_CNT_WIDTH-1:0]   drop_q, drop_d;
    logic [AXIS_TDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                        tvalid;
    logic                        full;
    logic                        pop;
    logic                        push;
    logic                        drop;
    logic [AXIS_TDATA_WIDTH-1:0] pkt;

    // Each channel sign-extended into its own half of the word.
    assign pkt = {HW'($signed(s1_b_q)), 16'($signed(s1_a_q))};

    assign tvalid = (level_q != '0);
    assign full   = (level_q == LW'(FIFO_DEPTH));
    assign pop    = tvalid && M_AXIS.tready && !clear_i;
    assign push   = s1_valid_q && !clear_i && (!full || pop);
    assign drop   = s1_valid_q && !clear_i && !push;

    always_comb begin
        s1_valid_d = accept;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        sat_d      = sat_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_d     = drop_q;

        if (accept) begin
            s1_a_d = a_in;
            s1_b_d = b_in;
            sat_d  = sat_q | clip;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        if (drop && drop_q != '1) begin
            drop_d = drop_q + DROP_CNT_WIDTH'(1);
        end

        if (clear_i) begin
            sat_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            drop_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            sat_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            sat_q      <= sat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkt;
        end
    end

    assign M_AXIS.tvalid = tvalid;
    assign M_AXIS.tdata  = tvalid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level_o  = level_q;
    assign drop_cnt_o    = drop_q;
    assign sat_flag_o    = sat_q;

endmodule
